iter_cmp: RTL and testbench
===========================

# iter_cmp

Parametrised, multi-cycle operand comparator for the pipelined MIPS datapath. It generalises the single-cycle 32-bit equality compare used for branch resolution to the following:
- any operand width;
- signed, unsigned and compare-against-zero modes (beq/bne/blt/bltu/bge/bgeu/blez/bgtz);
- a start/busy/done handshake.

Operands are scanned MSB-slice-first, SLICE bits per cycle, with early termination on the first differing slice. This trades latency for a short per-cycle compare path on wide operands.

## Interface
- WIDTH, 32, operand width in bits; must be a multiple of SLICE.
- SLICE, 8, bits compared per cycle; SLICE == WIDTH gives a single scan cycle. NSLICE = WIDTH/SLICE.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  request; accepted only when busy == 0.
- op  in  3  compare mode, sampled with start: 0 EQ, 1 NE, 2 LT (signed), 3 LTU, 4 GE (signed), 5 GEU, 6 LEZ (signed, b ignored), 7 GTZ (signed, b ignored).
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start; treated as 0 for op 6/7.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse; result valid.
- result  out  1  compare outcome; held from the done cycle until the next done.

## Operation
- States: IDLE, SCAN, FIN.
- IDLE / FIN with start=1 → capture, then go to SCAN with slice index k=0 (MSB slice).
- Capture (start accepted):
  - register a and b; register b as 0 when op is 6 or 7;
  - for signed ops (2, 4, 6, 7), invert bit WIDTH-1 of both captured operands. This maps the signed order onto the unsigned order;
  - register op.
- SCAN, one slice per cycle (slice k = bits [WIDTH-1-k*SLICE -: SLICE]):
  - if the slices differ: lt = (slice_a < slice_b) unsigned, eq = 0 → FIN;
  - else if k == NSLICE-1: eq = 1, lt = 0 → FIN;
  - else k = k+1, stay in SCAN.
- Result mapping from eq/lt: EQ=eq, NE=!eq, LT/LTU=lt, GE/GEU=!lt, LEZ=lt|eq, GTZ=!(lt|eq).
- FIN: done=1 and result updated for exactly this cycle; busy=0. Next state is IDLE, or SCAN if start=1 in this cycle.
- start while busy=1 is ignored; it is neither queued nor able to corrupt the captured operands.
- Changes on a/b/op while busy have no effect.
- k counter is $clog2(NSLICE) bits (min 1); it never exceeds NSLICE-1.

## Timing
- Reset (async assert, released synchronously by the environment): state=IDLE, busy=0, done=0, result=0, k=0, captured operands=0.
- Reset asserted mid-SCAN aborts the compare immediately; no done pulse follows.
- Start sampled high at edge t (busy=0) → busy=1 from t+1.
- Difference found in slice j (0-based, MSB first) at SCAN cycle t+1+j → done=1, busy=0, result valid during cycle t+2+j.
- Latency bounds: minimum 2 cycles (first slice differs), maximum NSLICE+1 cycles (equal operands, or difference only in the LSB slice). With defaults: 2..5.
- Back-to-back: start high in the FIN cycle is accepted. Throughput is one compare per (scan length + 1) cycles.
- done is never asserted for two consecutive cycles unless two separate compares each complete; consecutive completion is impossible since scan ≥ 1 cycle.
- result is registered; it does not change while busy.

## Test plan
- EQ, a=b=0x1234_5678, defaults: start at t → done at t+5, result=1. Same with op=NE → result=0.
- LTU, a=0x0100_0000, b=0x00FF_FFFF: early exit in slice 0 → done at t+2, result=0. Swap operands → result=1.
- LT signed, a=0xFFFF_FFFF, b=0x0000_0001 → result=1 at t+2. With op=LTU → result=0. GE signed with a=0x8000_0000, b=0x7FFF_FFFF → result=0.
- Zero modes, b=0xDEAD_BEEF (ignored):
  - GTZ a=0x8000_0000 → 0;
  - GTZ a=1 → 1 at t+5;
  - LEZ a=0 → 1 at t+5.
- Handshake:
  - start pulsed during busy with different a/b/op → no effect on the in-flight result;
  - start in the FIN cycle → second compare runs with no idle gap;
  - done is a single-cycle pulse.
- Reset: assert reset at t+2 of an EQ scan → busy=0, done=0, result=0 asynchronously; no done pulse after release. Parameter sweep SLICE=32 (1-cycle scan, done at t+2) and WIDTH=64, SLICE=16.

Source files
------------

// File: rtl/iter_cmp.sv
// iter_cmp: multi-cycle magnitude/equality comparator.
// Operands are captured on start and scanned MSB slice first, SLICE bits per
// cycle, stopping at the first slice that differs. Signed modes flip the sign
// bit of both captured operands so one unsigned slice compare serves all modes.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; result holds the last outcome
//   SCAN  | comparing slice k of the captured operands (busy=1)
//   FIN   | done pulse, fresh result visible; may accept a new start
module iter_cmp #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             result
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [2:0] OP_EQ  = 3'd0;
  localparam logic [2:0] OP_NE  = 3'd1;
  localparam logic [2:0] OP_LT  = 3'd2;
  localparam logic [2:0] OP_LTU = 3'd3;
  localparam logic [2:0] OP_GE  = 3'd4;
  localparam logic [2:0] OP_GEU = 3'd5;
  localparam logic [2:0] OP_LEZ = 3'd6;
  localparam logic [2:0] OP_GTZ = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic              result_q, result_d;

  logic              signed_op;
  logic [WIDTH-1:0]  cap_a, cap_b;
  logic [31:0]       slice_lo;
  logic [SLICE-1:0]  slice_a, slice_b;
  logic              slice_ne, slice_lt, last_slice;

  // Operand conditioning at capture time: zero modes drop b, signed modes
  // flip the sign bit so that signed order equals unsigned order.
  always_comb begin
    signed_op = (op == OP_LT) || (op == OP_GE) || (op == OP_LEZ) || (op == OP_GTZ);
    cap_a = a;
    cap_b = ((op == OP_LEZ) || (op == OP_GTZ)) ? '0 : b;
    if (signed_op) begin
      cap_a[WIDTH-1] = ~cap_a[WIDTH-1];
      cap_b[WIDTH-1] = ~cap_b[WIDTH-1];
    end
  end

  // Select the current slice; a shift keeps the index arithmetic width-neutral.
  always_comb begin
    slice_lo   = 32'((NSLICE - 1 - int'(k_q)) * SLICE);
    slice_a    = SLICE'(a_q >> slice_lo);
    slice_b    = SLICE'(b_q >> slice_lo);
    slice_ne   = (slice_a != slice_b);
    slice_lt   = (slice_a < slice_b);
    last_slice = (k_q == KW'(NSLICE - 1));
  end

  // Next-state, capture and result mapping.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        if (start) begin
          state_d = S_SCAN;
          k_d     = '0;
          a_d     = cap_a;
          b_d     = cap_b;
          op_d    = op;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (slice_ne || last_slice) begin
          state_d = S_FIN;
          // eq is !slice_ne here; lt only meaningful when slices differ
          case (op_q)
            OP_EQ:           result_d = !slice_ne;
            OP_NE:           result_d = slice_ne;
            OP_LT, OP_LTU:   result_d = slice_ne && slice_lt;
            OP_GE, OP_GEU:   result_d = !(slice_ne && slice_lt);
            OP_LEZ:          result_d = (slice_ne && slice_lt) || !slice_ne;
            OP_GTZ:          result_d = !((slice_ne && slice_lt) || !slice_ne);
            default:         result_d = 1'b0;
          endcase
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any scan in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    busy   = (state_q == S_SCAN);
    done   = (state_q == S_FIN);
    result = result_q;
  end

endmodule

// File: tb/tb_iter_cmp.sv
// Bench for iter_cmp: three instances (32/8, 64/16, 32/32) share stimulus and
// are checked every cycle against an arithmetic reference model.
module tb_iter_cmp;

  localparam int WV[3] = '{32, 64, 32};
  localparam int SV[3] = '{8, 16, 32};

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [63:0] a64, b64;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic        res0, res1, res2;
  logic [2:0]  busy_v, done_v, res_v;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  // Model state per instance
  int cnt[3];
  bit mbusy[3], mdone[3], mres[3], pres[3];

  assign busy_v = {busy2, busy1, busy0};
  assign done_v = {done2, done1, done0};
  assign res_v  = {res2, res1, res0};

  iter_cmp #(.WIDTH(32), .SLICE(8)) u0 (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a64[31:0]), .b(b64[31:0]), .busy(busy0), .done(done0), .result(res0));

  iter_cmp #(.WIDTH(64), .SLICE(16)) u1 (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a64), .b(b64), .busy(busy1), .done(done1), .result(res1));

  iter_cmp #(.WIDTH(32), .SLICE(32)) u2 (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a64[31:0]), .b(b64[31:0]), .busy(busy2), .done(done2), .result(res2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: compare by value, latency from the first differing MSB slice.
  function automatic void ref_cmp(input int w, input int s, input logic [2:0] o,
                                  input logic [63:0] ai, input logic [63:0] bi,
                                  output bit res, output int lat);
    logic [63:0] m, sm, av, bv, sa, sb;
    bit eq, lt;
    int ns;
    m  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    sm = (s >= 64) ? '1 : ((64'd1 << s) - 64'd1);
    av = ai & m;
    bv = (o == 3'd6 || o == 3'd7) ? 64'd0 : (bi & m);
    sa = (((av >> (w - 1)) & 64'd1) != 0) ? (av | ~m) : av;
    sb = (((bv >> (w - 1)) & 64'd1) != 0) ? (bv | ~m) : bv;
    eq = (av == bv);
    if (o == 3'd2 || o == 3'd4 || o == 3'd6 || o == 3'd7) lt = ($signed(sa) < $signed(sb));
    else lt = (av < bv);
    case (o)
      3'd0: res = eq;
      3'd1: res = !eq;
      3'd2, 3'd3: res = lt;
      3'd4, 3'd5: res = !lt;
      3'd6: res = lt | eq;
      default: res = !(lt | eq);
    endcase
    ns = w / s;
    lat = ns + 1;
    for (int j = 0; j < ns; j++) begin
      if ((((av ^ bv) >> (w - (j + 1) * s)) & sm) != 64'd0) begin
        lat = j + 2;
        break;
      end
    end
  endfunction

  // Behavioural model: a countdown per instance from accept to done.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        cnt[i] = 0; mbusy[i] = 0; mdone[i] = 0; mres[i] = 0; pres[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit was_busy, r;
        int l;
        was_busy = mbusy[i];
        mdone[i] = 0;
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            mdone[i] = 1; mres[i] = pres[i]; mbusy[i] = 0;
          end
        end
        if (!was_busy && start) begin
          ref_cmp(WV[i], SV[i], op, a64, b64, r, l);
          pres[i] = r; cnt[i] = l - 1; mbusy[i] = 1;
        end
      end
    end
  end

  // Compare process: every output of every instance, every cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        chk1($sformatf("busy%0d", i), busy_v[i], mbusy[i]);
        chk1($sformatf("done%0d", i), done_v[i], mdone[i]);
        chk1($sformatf("result%0d", i), res_v[i], mres[i]);
      end
    end
  end

  task automatic idle_wait();
    start = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // Directed compare with literal expectations on one instance.
  task automatic directed(input string name, input int inst, input logic [2:0] o,
                          input logic [63:0] av, input logic [63:0] bv,
                          input bit exp_res, input int exp_lat, input bit poke);
    bit seen;
    idle_wait();
    op = o; a64 = av; b64 = bv; start = 1'b1;
    seen = 0;
    for (int c = 1; c <= 12 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = poke;
        if (poke) begin
          op = ~o; a64 = ~av; b64 = {$urandom, $urandom};
        end
      end else begin
        start = 1'b0;
      end
      if (done_v[inst]) begin
        seen = 1;
        chk1({name, "_res"}, res_v[inst], exp_res);
        chk_int({name, "_lat"}, c, exp_lat);
      end
    end
    if (!seen) chk_int({name, "_timeout"}, 0, 1);
  endtask

  task automatic back_to_back();
    bit seen;
    idle_wait();
    op = 3'd0; a64 = 64'h1234_5678; b64 = 64'h1234_5678; start = 1'b1;
    seen = 0;
    for (int c = 1; c <= 12 && !seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done0) begin
        seen = 1;
        chk1("b2b_first_res", res0, 1'b1);
        op = 3'd3; a64 = 64'h0100_0000; b64 = 64'h00FF_FFFF; start = 1'b1;
      end
    end
    if (!seen) chk_int("b2b_first_timeout", 0, 1);
    @(negedge clk);
    start = 1'b0;
    chk1("b2b_no_gap_busy", busy0, 1'b1);
    chk1("b2b_single_pulse", done0, 1'b0);
    @(negedge clk);
    chk1("b2b_second_done", done0, 1'b1);
    chk1("b2b_second_res", res0, 1'b0);
  endtask

  task automatic reset_abort();
    int n;
    directed("lez_pre", 0, 3'd6, 64'h0, 64'h0, 1'b1, 5, 0);
    idle_wait();
    op = 3'd0; a64 = 64'hCAFE_F00D; b64 = 64'hCAFE_F00D; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk1("rst_async_busy", busy0, 1'b0);
    chk1("rst_async_done", done0, 1'b0);
    chk1("rst_async_result", res0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (done0) n++;
    end
    chk_int("rst_no_done", n, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd0; a64 = '0; b64 = '0;
    repeat (3) @(negedge clk);
    chk1("reset_busy", busy0, 1'b0);
    chk1("reset_done", done0, 1'b0);
    chk1("reset_result", res0, 1'b0);
    reset = 1'b1;
    cmp_en = 1;

    directed("eq",      0, 3'd0, 64'h1234_5678, 64'h1234_5678, 1'b1, 5, 0);
    directed("ne",      0, 3'd1, 64'h1234_5678, 64'h1234_5678, 1'b0, 5, 0);
    directed("ltu",     0, 3'd3, 64'h0100_0000, 64'h00FF_FFFF, 1'b0, 2, 0);
    directed("ltu_sw",  0, 3'd3, 64'h00FF_FFFF, 64'h0100_0000, 1'b1, 2, 0);
    directed("lt_s",    0, 3'd2, 64'hFFFF_FFFF, 64'h0000_0001, 1'b1, 2, 0);
    directed("ltu_neg", 0, 3'd3, 64'hFFFF_FFFF, 64'h0000_0001, 1'b0, 2, 0);
    directed("ge_s",    0, 3'd4, 64'h8000_0000, 64'h7FFF_FFFF, 1'b0, 2, 0);
    directed("gtz_neg", 0, 3'd7, 64'h8000_0000, 64'hDEAD_BEEF, 1'b0, 2, 0);
    directed("gtz_one", 0, 3'd7, 64'h0000_0001, 64'hDEAD_BEEF, 1'b1, 5, 0);
    directed("lez_zero",0, 3'd6, 64'h0000_0000, 64'hDEAD_BEEF, 1'b1, 5, 0);
    directed("poke",    0, 3'd0, 64'h1234_5678, 64'h1234_5678, 1'b1, 5, 1);
    directed("s32_eq",  2, 3'd0, 64'h1234_5678, 64'h1234_5678, 1'b1, 2, 0);
    directed("w64_eq",  1, 3'd0, 64'h1234_5678, 64'h1234_5678, 1'b1, 5, 0);
    directed("w64_lsb", 1, 3'd5, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 1'b0, 5, 0);
    back_to_back();
    reset_abort();

    for (int it = 0; it < 600; it++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) != 0);
      op = 3'($urandom_range(0, 7));
      a64 = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b64 = {$urandom, $urandom};
        1: b64 = a64;
        2: b64 = a64 ^ (64'd1 << $urandom_range(0, 63));
        default: begin
          a64 = 64'($urandom_range(0, 3)) - 64'd1;
          b64 = 64'($urandom_range(0, 3));
        end
      endcase
    end
    start = 1'b0;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
